// File: rtl/cic_pkg.sv
// cic_pkg: shared sizing, I/Q pair type and round/saturate helper for the CIC decimator
package cic_pkg;
  localparam int IQ_WIDTH = 24;
  typedef struct packed {
    logic signed [IQ_WIDTH-1:0] inph;
    logic signed [IQ_WIDTH-1:0] quad;
  } iq_t;
  function automatic int acc_width(input int in_w, input int max_rate, input int delay, input int stages);
    return in_w + stages * $clog2(max_rate * delay);
  endfunction
  // 128-bit working width leaves headroom for the rounding add on a full-scale accumulator
  function automatic logic signed [127:0] round_sat(input logic signed [127:0] v, input int sh, input int w, output logic ovf);
    logic signed [127:0] hi, r;
    hi = (128'sd1 <<< (w - 1)) - 128'sd1;
    r = (v + (sh > 0 ? 128'sd1 <<< (sh - 1) : 128'sd0)) >>> sh;
    ovf = r > hi || r < ~hi;
    return ovf ? (r[127] ? ~hi : hi) : r;
  endfunction
endpackage

// File: rtl/cic_rail.sv
// cic_rail: one rail of the CIC decimator, integrator chain, comb chain and round/saturate
module cic_rail import cic_pkg::*; #(
  parameter int IN_WIDTH = 16,
  parameter int OUT_WIDTH = 24,
  parameter int STAGES = 5,
  parameter int DELAY = 2,
  parameter int ACC_WIDTH = 66,
  parameter int SHIFT_W = 7
) (
  input  logic i_clock,
  input  logic clr,
  input  logic signed [IN_WIDTH-1:0] din,
  input  logic [STAGES-1:0] int_en,
  input  logic [STAGES-1:0] comb_en,
  input  logic out_en,
  input  logic [SHIFT_W-1:0] shift,
  output logic signed [OUT_WIDTH-1:0] dout,
  output logic ovf
);
  logic [STAGES-1:0][ACC_WIDTH-1:0] integ, comb, isrc, csrc;
  logic [STAGES-1:0][DELAY-1:0][ACC_WIDTH-1:0] dly;
  logic signed [OUT_WIDTH-1:0] y;
  logic sat;
  assign isrc = {integ[STAGES-2:0], ACC_WIDTH'(din)};
  assign csrc = {comb[STAGES-2:0], integ[STAGES-1]};
  always_comb y = OUT_WIDTH'(round_sat(128'(signed'(comb[STAGES-1])), int'(shift), OUT_WIDTH, sat));
  always_ff @(posedge i_clock)
    if (clr) begin
      integ <= '0;
      comb <= '0;
      dly <= '0;
      dout <= '0;
      ovf <= 1'b0;
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (int_en[k]) integ[k] <= integ[k] + isrc[k];
        if (comb_en[k]) begin
          comb[k] <= csrc[k] - dly[k][DELAY-1];
          dly[k][0] <= csrc[k];
          for (int j = 1; j < DELAY; j++) dly[k][j] <= dly[k][j-1];
        end
      end
      if (out_en) begin
        dout <= y;
        ovf <= sat;
      end
    end
endmodule

// File: rtl/cic_decim_prog.sv
// cic_decim_prog: I/Q CIC decimator with runtime rate/shift; the load strobe also clears all datapath state
module cic_decim_prog import cic_pkg::*; #(
  parameter int IN_WIDTH = 16,
  parameter int OUT_WIDTH = 24,
  parameter int MAX_RATE = 512,
  parameter int STAGES = 5,
  parameter int DELAY = 2,
  parameter int ACC_WIDTH = acc_width(IN_WIDTH, MAX_RATE, DELAY, STAGES),
  parameter int RATE_W = $clog2(MAX_RATE + 1),
  parameter int SHIFT_W = $clog2(ACC_WIDTH)
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic signed [IN_WIDTH-1:0] i_inph_data,
  input  logic signed [IN_WIDTH-1:0] i_quad_data,
  input  logic i_valid,
  input  logic [RATE_W-1:0] i_rate,
  input  logic [SHIFT_W-1:0] i_shift,
  input  logic i_cfg_load,
  output logic signed [OUT_WIDTH-1:0] o_inph_data,
  output logic signed [OUT_WIDTH-1:0] o_quad_data,
  output logic o_valid,
  output logic o_overflow,
  output logic [RATE_W-1:0] o_rate
);
  localparam int P = 2 * STAGES;
  logic clr, ovf_i, ovf_q, oen;
  logic [RATE_W-1:0] rate_c, cnt;
  logic [SHIFT_W-1:0] shift;
  logic [P-1:0] vp, dp;
  logic [P:0] vv, dd;
  logic [STAGES-1:0] cen;
  assign clr = i_reset | i_cfg_load;
  assign rate_c = i_rate < RATE_W'(2) ? RATE_W'(2) : i_rate > RATE_W'(MAX_RATE) ? RATE_W'(MAX_RATE) : i_rate;
  // valid and decim tag travel side by side, one bit per pipeline register
  assign vv = {vp, i_valid};
  assign dd = {dp, cnt == o_rate - RATE_W'(1)};
  assign cen = vv[P-1:STAGES] & dd[P-1:STAGES];
  assign oen = vv[P] & dd[P];
  assign o_overflow = ovf_i | ovf_q;
  always_ff @(posedge i_clock)
    if (clr) begin
      o_rate <= rate_c;
      shift <= i_shift;
      cnt <= '0;
      vp <= '0;
      dp <= '0;
      o_valid <= 1'b0;
    end else begin
      if (i_valid) cnt <= dd[0] ? '0 : cnt + RATE_W'(1);
      vp <= vv[P-1:0];
      dp <= dd[P-1:0];
      o_valid <= oen;
    end
  cic_rail #(.IN_WIDTH(IN_WIDTH), .OUT_WIDTH(OUT_WIDTH), .STAGES(STAGES), .DELAY(DELAY),
    .ACC_WIDTH(ACC_WIDTH), .SHIFT_W(SHIFT_W)) u_inph (
    .i_clock(i_clock), .clr(clr), .din(i_inph_data), .int_en(vv[STAGES-1:0]), .comb_en(cen),
    .out_en(oen), .shift(shift), .dout(o_inph_data), .ovf(ovf_i));
  cic_rail #(.IN_WIDTH(IN_WIDTH), .OUT_WIDTH(OUT_WIDTH), .STAGES(STAGES), .DELAY(DELAY),
    .ACC_WIDTH(ACC_WIDTH), .SHIFT_W(SHIFT_W)) u_quad (
    .i_clock(i_clock), .clr(clr), .din(i_quad_data), .int_en(vv[STAGES-1:0]), .comb_en(cen),
    .out_en(oen), .shift(shift), .dout(o_quad_data), .ovf(ovf_q));
endmodule

// File: doc/cic_decim_prog.md
Name: cic_decim_prog

Overview:
- I/Q CIC decimator with runtime-programmable rate and output shift, and independent input and output widths.
- Each output is rounded and saturated; an overflow flag accompanies it.
- Successor to the fixed-FACTOR cic_decim; sits between the NCO mixer and the channel FIR in the receive chain.
- Config changes are applied through an explicit load strobe that also clears all datapath state, so a new rate never mixes with stale integrator contents.

Parameters:
IN_WIDTH, 16, signed input sample width per rail
OUT_WIDTH, 24, signed output sample width per rail
MAX_RATE, 512, largest supported decimation rate
STAGES, 5, integrator/comb stage count N
DELAY, 2, comb differential delay M (1 or 2)
ACC_WIDTH, IN_WIDTH+STAGES*$clog2(MAX_RATE*DELAY) (=66), internal two's-complement width
RATE_W, $clog2(MAX_RATE+1), width of i_rate
SHIFT_W, $clog2(ACC_WIDTH), width of i_shift

Ports:
i_clock  in  1  clock
i_reset  in  1  synchronous, active-high reset
i_inph_data  in  IN_WIDTH  signed I sample
i_quad_data  in  IN_WIDTH  signed Q sample
i_valid  in  1  input sample strobe; gaps allowed
i_rate  in  RATE_W  requested decimation rate R
i_shift  in  SHIFT_W  requested arithmetic right shift applied before output
i_cfg_load  in  1  latch i_rate/i_shift and clear datapath
o_inph_data  out  OUT_WIDTH  signed I output
o_quad_data  out  OUT_WIDTH  signed Q output
o_valid  out  1  output strobe
o_overflow  out  1  either rail saturated this output; meaningful only with o_valid
o_rate  out  RATE_W  active rate, after clamping

Behaviour:
- Reset:
  - All integrators, combs, decimation counter and valid pipeline are cleared to 0.
  - o_valid, o_overflow and both data outputs are 0.
  - The active rate and shift registers load from i_rate/i_shift every reset cycle.
- Rate clamp: a requested R<2 becomes 2; R>MAX_RATE becomes MAX_RATE. o_rate shows the clamped value.
- i_cfg_load=1 (not in reset):
  - Next cycle, the active rate/shift take the sampled ports.
  - All datapath state clears exactly as at reset; outputs still in flight are dropped.
  - An i_valid in the same cycle as the load is discarded.
- Integrators:
  - STAGES pipelined registers, all ACC_WIDTH wide. I_0 is the input sign-extended.
  - Stage k updates I_k <= I_k + I_(k-1) when its incoming valid bit is set.
  - Wrap-around (modular) arithmetic, no saturation; ACC_WIDTH guarantees comb recovery.
- Decimation counter:
  - Counts accepted input samples 0..R-1.
  - The R-th sample is tagged with a decim bit, which travels with the valid pipeline.
  - The counter wraps to 0 after the tagged sample.
- Combs:
  - STAGES pipelined registers, each advancing only on a tagged sample.
  - C_k = x - x delayed M decimated samples. Delay lines clear to 0.
- Output stage, one register:
  - y = comb >>> shift. When shift>0, add 2^(shift-1) before the shift (round half up).
  - Saturate to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1]; o_overflow=1 if either rail clipped.
- Latency: o_valid fires exactly 2*STAGES+1 cycles after the i_valid cycle of every R-th accepted sample, independent of input gaps.
- Throughput and gain: one input per cycle maximum. DC gain = (R*M)^STAGES.
- Steady state: exactly floor(accepted_samples/R) outputs since the last clear.
- Simultaneous reset and i_cfg_load: reset wins.
- Data outputs hold their last value while o_valid=0.

Decomposition:
- Package cic_pkg holds:
  - a function computing ACC_WIDTH from IN_WIDTH/MAX_RATE/DELAY/STAGES;
  - a round/saturate function parameterised by width;
  - a typedef for the packed I/Q pair.
- One sub-module, cic_rail: integrator chain, comb chain and round/saturate for a single rail.
  - It is instantiated twice (I and Q).
  - The top level owns the config registers, clamping, decimation counter and valid/decim pipeline.

Test Plan:
- Idle: reset, no i_valid for 1000 cycles -> zero o_valid pulses.
- Count: R=313, 4*3130 valid samples (no gaps) -> exactly 40 outputs. Repeat with i_valid toggled every other cycle -> still 40 outputs, each at latency 11 cycles.
- DC gain: R=4, M=2, N=5, shift=15, input I=+1, Q=-1 -> settled outputs I=+1, Q=-1 (gain 32768), o_overflow=0. First settled output appears at output index >=3.
- Rounding: R=4, shift=16, DC input +3/-3 -> settled outputs +2/-1 (1.5 and -1.5 rounded half up).
- Saturation: R=512, shift=0, DC +32767/-32768 -> outputs 8388607/-8388608 with o_overflow=1 on every settled output.
- Reconfigure mid-stream:
  - Setup: run at R=10, pulse i_cfg_load with i_rate=1 while sending valid samples.
  - o_rate=2; no in-flight outputs emerge after the load.
  - The next output follows the 2nd sample accepted after the load.
  - Then 200 samples -> 100 outputs.
  - Same sequence with i_reset instead -> identical results.
